serial_subtractor_ctrl: RTL

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

---
 rtl/serial_subtractor_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a-b LSB first through a single full_subtractor cell.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output (ovf).

module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic D,
    output logic B
);
    assign D = X ^ Y ^ Z;
    assign B = (~X & Y) | (~(X ^ Y) & Z);
endmodule

module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);
    // Counter is sized to hold WIDTH so the final increment never wraps.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [WIDTH-1:0]  r_a_sh, w_a_sh_d;
    logic [WIDTH-1:0]  r_b_sh, w_b_sh_d;
    logic [WIDTH-1:0]  r_res, w_res_d;
    logic [WIDTH-1:0]  r_diff, w_diff_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              r_bint, w_bint_d;
    logic              r_busy, w_busy_d;
    logic              r_done, w_done_d;
    logic              r_borrow, w_borrow_d;
    logic              w_fs_d, w_fs_b;
    logic [WIDTH-1:0]  w_res_shift;
    logic              w_last;
`ifdef SERIAL_SUB_OVF_EN
    logic              r_a_msb, w_a_msb_d;
    logic              r_b_msb, w_b_msb_d;
    logic              r_ovf, w_ovf_d;
`endif

    full_subtractor u_fs (
        .X(r_a_sh[0]),
        .Y(r_b_sh[0]),
        .Z(r_bint),
        .D(w_fs_d),
        .B(w_fs_b)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign w_res_shift = (r_res >> 1) | (WIDTH'(w_fs_d) << (WIDTH - 1));
    assign w_last      = (r_cnt == CntW'(WIDTH - 1));

    always_comb begin
        w_state_d  = r_state;
        w_a_sh_d   = r_a_sh;
        w_b_sh_d   = r_b_sh;
        w_res_d    = r_res;
        w_diff_d   = r_diff;
        w_cnt_d    = r_cnt;
        w_bint_d   = r_bint;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;
        w_borrow_d = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
        w_a_msb_d  = r_a_msb;
        w_b_msb_d  = r_b_msb;
        w_ovf_d    = r_ovf;
`endif
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StRun;
                    w_a_sh_d  = a;
                    w_b_sh_d  = b;
                    w_res_d   = '0;
                    w_cnt_d   = '0;
                    w_bint_d  = 1'b0;
                    w_busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    w_a_msb_d = a[WIDTH-1];
                    w_b_msb_d = b[WIDTH-1];
`endif
                end
            end
            StRun: begin
                w_a_sh_d = r_a_sh >> 1;
                w_b_sh_d = r_b_sh >> 1;
                w_res_d  = w_res_shift;
                w_bint_d = w_fs_b;
                w_cnt_d  = r_cnt + CntW'(1);
                if (w_last) begin
                    w_state_d  = StDone;
                    w_diff_d   = w_res_shift;
                    w_borrow_d = w_fs_b;
                    w_done_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    w_ovf_d    = (r_a_msb != r_b_msb) && (w_res_shift[WIDTH-1] != r_a_msb);
`endif
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bint   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_a_sh   <= w_a_sh_d;
            r_b_sh   <= w_b_sh_d;
            r_res    <= w_res_d;
            r_diff   <= w_diff_d;
            r_cnt    <= w_cnt_d;
            r_bint   <= w_bint_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_borrow <= w_borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= w_a_msb_d;
            r_b_msb  <= w_b_msb_d;
            r_ovf    <= w_ovf_d;
`endif
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = r_ovf;
`endif

endmodule
